// File: rtl/systola_pkg.sv
// rtl/systola_pkg.sv - shared types and defaults for the systolic array feeders
package systola_pkg;

  localparam int DEF_WORDLEN = 8;
  localparam int DEF_NROWS   = 4;

  // Feeder states kept as plain 2-bit constants so older tools and wave scripts decode them directly
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FEED = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    FEED = ST_FEED,
    DONE = ST_DONE
  } feed_state_t;

endpackage

// File: rtl/inbuf_feed_ctrl_if.sv
// rtl/inbuf_feed_ctrl_if.sv - host word stream plus input FIFO bank signals
interface inbuf_feed_ctrl_if #(
  parameter int WORDLEN = systola_pkg::DEF_WORDLEN,
  parameter int NROWS   = systola_pkg::DEF_NROWS
);
  logic               in_valid;
  logic               in_ready;
  logic [WORDLEN-1:0] in_data;
  logic [NROWS-1:0]   buf_wr;
  logic [WORDLEN-1:0] buf_din;
  logic [NROWS-1:0]   buf_rd;
  logic [NROWS-1:0]   buf_empty;

  // Controller side
  modport master (
    input  in_valid, in_data, buf_empty,
    output in_ready, buf_wr, buf_din, buf_rd
  );

  // Host and FIFO bank side
  modport slave (
    output in_valid, in_data, buf_empty,
    input  in_ready, buf_wr, buf_din, buf_rd
  );
endinterface

// File: rtl/inbuf_feed_ctrl_skew_decode.sv
// rtl/inbuf_feed_ctrl_skew_decode.sv - diagonal read-strobe decode from feed time and tile depth
module skew_decode #(
  parameter int NROWS = systola_pkg::DEF_NROWS,
  parameter int KW    = 5
) (
  input  logic             active,
  input  logic [KW-1:0]    t,
  input  logic [KW-1:0]    k,
  output logic [NROWS-1:0] rd
);
  // Row r is live for feed times r .. r+k-1; compared one bit wider so r+k cannot wrap
  for (genvar r = 0; r < NROWS; r++) begin : g_row
    localparam logic [KW:0] RV = (KW+1)'(r);
    assign rd[r] = active && ({1'b0, t} >= RV) && ({1'b0, t} < (RV + {1'b0, k}));
  end
endmodule

// File: rtl/inbuf_feed_ctrl.sv
// rtl/inbuf_feed_ctrl.sv - load/feed sequencer for the systolic array input FIFO bank
module inbuf_feed_ctrl
  import systola_pkg::*;
#(
  parameter int WORDLEN = DEF_WORDLEN,
  parameter int NROWS   = DEF_NROWS,
  parameter int MAXK    = 8,
  parameter int KW      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        cfg_k,
  inbuf_feed_ctrl_if.master    bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1;

  logic [1:0]       state;
  logic [KW-1:0]    k_reg;
  logic [KW-1:0]    col;
  logic [KW-1:0]    t;
  logic [RW-1:0]    row;
  logic             hs;
  logic             last_col;
  logic             last_word;
  logic             last_t;
  logic             cfg_bad;
  logic             underrun;
  logic [NROWS-1:0] rd_vec;

  assign bus.in_ready = (state == ST_LOAD);
  assign hs           = bus.in_valid && bus.in_ready;
  assign last_col     = (col == (k_reg - KW'(1)));
  assign last_word    = last_col && (row == RW'(NROWS - 1));
  assign last_t       = (t == (k_reg + KW'(NROWS - 2)));
  assign cfg_bad      = (cfg_k == '0) || (cfg_k > KW'(MAXK));
  assign bus.buf_din  = WORDLEN'(bus.in_data);
  assign busy         = (state == ST_LOAD) || (state == ST_FEED);
  assign done         = (state == ST_DONE);

  skew_decode #(
    .NROWS (NROWS),
    .KW    (KW)
  ) u_skew (
    .active (state == ST_FEED),
    .t      (t),
    .k      (k_reg),
    .rd     (rd_vec)
  );

  assign bus.buf_rd = rd_vec;
  assign underrun   = |(rd_vec & bus.buf_empty);

  // One-hot write strobe to the row currently being filled, only on an accepted word
  always_comb begin
    bus.buf_wr = '0;
    if (hs) begin
      bus.buf_wr[row] = 1'b1;
    end
  end

  // Tile sequencer: config check, row-major load counters, feed time, sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      k_reg <= '0;
      col   <= '0;
      row   <= '0;
      t     <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              k_reg <= cfg_k;
              col   <= '0;
              row   <= '0;
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (hs) begin
            if (last_col) begin
              col <= '0;
              if (last_word) begin
                row   <= '0;
                t     <= '0;
                state <= ST_FEED;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + KW'(1);
            end
          end
        end
        ST_FEED: begin
          // An empty FIFO being read is flagged but the wavefront keeps moving
          if (underrun) begin
            err <= 1'b1;
          end
          if (last_t) begin
            t     <= '0;
            state <= ST_DONE;
          end else begin
            t <= t + KW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inbuf_feed_ctrl.sv
// tb/tb_inbuf_feed_ctrl.sv - directed self-checking bench for inbuf_feed_ctrl
module tb_inbuf_feed_ctrl;
  import systola_pkg::*;

  localparam int NR   = 4;
  localparam int KW   = 5;
  localparam int MAXK = 8;
  localparam int WL   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] cfg_k = '0;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int failures = 0;

  logic [3:0] basic_rd [6];
  logic [3:0] k2_rd [5];

  inbuf_feed_ctrl_if #(.WORDLEN(WL), .NROWS(NR)) bus ();

  inbuf_feed_ctrl #(
    .WORDLEN (WL),
    .NROWS   (NR),
    .MAXK    (MAXK),
    .KW      (KW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cfg_k (cfg_k),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tile(input int k, input int gap_a, input int gap_b);
    start = 1'b1;
    cfg_k = KW'(k);
    tick();
    start = 1'b0;
    cfg_k = '0;
    #1;
    chk("load_ready", 32'(bus.in_ready), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    for (int i = 0; i < k * NR; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WL'(i + 1);
      #1;
      chk("load_wr", 32'(bus.buf_wr), 32'(1 << (i / k)));
      chk("load_din", 32'(bus.buf_din), 32'(i + 1));
      tick();
      if (i == gap_a || i == gap_b) begin
        for (int g = 0; g < 2; g++) begin
          bus.in_valid = 1'b0;
          #1;
          chk("gap_wr", 32'(bus.buf_wr), 32'd0);
          chk("gap_ready", 32'(bus.in_ready), 32'd1);
          tick();
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_done(input logic exp_err);
    #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_err", 32'(err), 32'(exp_err));
    tick();
    #1;
    chk("done_clear", 32'(done), 32'd0);
    chk("idle_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic run_feed(input int k, input int empty_t);
    logic [3:0] e;
    for (int tt = 0; tt <= k + NR - 2; tt++) begin
      bus.buf_empty = (tt == empty_t) ? 4'b0100 : 4'b0000;
      #1;
      for (int r = 0; r < NR; r++) e[r] = (tt >= r) && (tt < r + k);
      chk("feed_rd", 32'(bus.buf_rd), 32'(e));
      chk("feed_done", 32'(done), 32'd0);
      chk("feed_busy", 32'(busy), 32'd1);
      if (empty_t >= 0) chk("underrun_err", 32'(err), 32'(tt > empty_t));
      tick();
    end
    bus.buf_empty = '0;
    check_done(empty_t >= 0);
  endtask

  initial begin
    basic_rd = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    k2_rd    = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000};
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.buf_empty = '0;

    // reset state
    #2;
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr", 32'(bus.buf_wr), 32'd0);
    chk("rst_rd", 32'(bus.buf_rd), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("idle_ready0", 32'(bus.in_ready), 32'd0);

    // basic load k=3 and hand-tabled skewed feed
    load_tile(3, -1, -1);
    for (int j = 0; j < 6; j++) begin
      #1;
      chk("basic_rd", 32'(bus.buf_rd), 32'(basic_rd[j]));
      chk("basic_ready", 32'(bus.in_ready), 32'd0);
      chk("basic_done", 32'(done), 32'd0);
      tick();
    end
    check_done(1'b0);

    // gaps after words 2 and 7
    load_tile(3, 1, 6);
    run_feed(3, -1);

    // bad config: k=0 then k=9
    start = 1'b1;
    cfg_k = 5'd0;
    tick();
    start = 1'b0;
    #1;
    chk("bad0_err", 32'(err), 32'd1);
    chk("bad0_ready", 32'(bus.in_ready), 32'd0);
    chk("bad0_busy", 32'(busy), 32'd0);
    chk("bad0_done", 32'(done), 32'd0);
    start = 1'b1;
    cfg_k = 5'd9;
    tick();
    start = 1'b0;
    cfg_k = '0;
    #1;
    chk("bad9_err", 32'(err), 32'd1);
    chk("bad9_ready", 32'(bus.in_ready), 32'd0);
    chk("bad9_done", 32'(done), 32'd0);
    tick();
    #1;
    chk("bad9_ready2", 32'(bus.in_ready), 32'd0);
    chk("bad9_done2", 32'(done), 32'd0);
    rst = 1'b1;
    #1;
    chk("err_cleared", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // underrun on row 2 at t=2
    load_tile(3, -1, -1);
    run_feed(3, 2);

    // reset at t=1 of FEED, then a fresh k=2 tile
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    tick();
    load_tile(3, -1, -1);
    #1;
    chk("mid_rd_t0", 32'(bus.buf_rd), 32'b0001);
    tick();
    #1;
    chk("mid_rd_t1", 32'(bus.buf_rd), 32'b0011);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd", 32'(bus.buf_rd), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      #1;
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_rd", 32'(bus.buf_rd), 32'd0);
    end
    load_tile(2, -1, -1);
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("k2_rd", 32'(bus.buf_rd), 32'(k2_rd[j]));
      chk("k2_done", 32'(done), 32'd0);
      tick();
    end
    check_done(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
